// File: rtl/uart_receive_framed.sv
// UART receiver with configurable framing, input synchroniser, break detection
// and a show-ahead output FIFO with valid/ready handshake.
module uart_receive_framed #(
    parameter int INPUT_CLOCK_FREQ = 100_000_000,
    parameter int BAUD_RATE        = 9600,
    parameter int DATA_BITS        = 8,
    parameter int PARITY           = 0,
    parameter int STOP_BITS        = 1,
    parameter int FIFO_DEPTH       = 4
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic                          rx_wire_in,
    output logic [DATA_BITS-1:0]          data_out,
    output logic                          parity_err_out,
    output logic                          framing_err_out,
    output logic                          valid_out,
    input  logic                          ready_in,
    output logic                          overrun_out,
    output logic                          break_out,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_out
);

    localparam int BAUD_BIT_PERIOD = INPUT_CLOCK_FREQ / BAUD_RATE;
    localparam int HALF            = BAUD_BIT_PERIOD >> 1;
    localparam int CW              = $clog2(BAUD_BIT_PERIOD);
    localparam int PW              = $clog2(FIFO_DEPTH);
    localparam int EW              = DATA_BITS + 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP,
        S_BREAK_WAIT
    } state_t;

    state_t               state;
    logic                 rx_meta;
    logic                 rx_s;
    logic [CW-1:0]        cyc;
    logic [3:0]           bit_cnt;
    logic                 stop_cnt;
    logic [DATA_BITS-1:0] shift;
    logic                 acc;
    logic                 par_bit;
    logic                 parity_err;
    logic                 framing_err;

    logic                 at_half;
    logic                 at_wrap;
    logic                 last_stop;
    logic                 fe_next;
    logic                 is_break;
    logic                 push;

    logic [EW-1:0]        mem [FIFO_DEPTH];
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [PW:0]          count;
    logic                 full;
    logic                 pop;
    logic                 wr_en;
    logic [EW-1:0]        head;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx_wire_in;
            rx_s    <= rx_meta;
        end
    end

    // Completion is decided at the last stop-bit sample, so the error flag and
    // break decision must include the bit being sampled on this edge.
    always_comb begin
        at_half   = (cyc == CW'(HALF));
        at_wrap   = (cyc == CW'(BAUD_BIT_PERIOD - 1));
        last_stop = (state == S_STOP) && at_half && (stop_cnt == 1'(STOP_BITS - 1));
        fe_next   = framing_err | ~rx_s;
        is_break  = fe_next && (shift == '0) && ((PARITY == 0) || !par_bit);
        push      = last_stop && !is_break;
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state       <= S_IDLE;
            cyc         <= '0;
            bit_cnt     <= '0;
            stop_cnt    <= 1'b0;
            shift       <= '0;
            acc         <= 1'b0;
            par_bit     <= 1'b0;
            parity_err  <= 1'b0;
            framing_err <= 1'b0;
            break_out   <= 1'b0;
        end else begin
            break_out <= last_stop && is_break;
            cyc       <= at_wrap ? '0 : cyc + 1'b1;
            case (state)
                S_IDLE: begin
                    cyc         <= '0;
                    bit_cnt     <= '0;
                    stop_cnt    <= 1'b0;
                    shift       <= '0;
                    acc         <= 1'b0;
                    par_bit     <= 1'b0;
                    parity_err  <= 1'b0;
                    framing_err <= 1'b0;
                    if (!rx_s) state <= S_START;
                end
                S_START: begin
                    if (at_half && rx_s) state <= S_IDLE;
                    else if (at_wrap)    state <= S_DATA;
                end
                S_DATA: begin
                    if (at_half) begin
                        shift   <= {rx_s, shift[DATA_BITS-1:1]};
                        acc     <= acc ^ rx_s;
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                    if (at_wrap && bit_cnt == 4'(DATA_BITS))
                        state <= (PARITY != 0) ? S_PARITY : S_STOP;
                end
                S_PARITY: begin
                    if (at_half) begin
                        par_bit    <= rx_s;
                        parity_err <= (acc ^ rx_s) != (PARITY == 2);
                    end
                    if (at_wrap) state <= S_STOP;
                end
                S_STOP: begin
                    if (at_half) begin
                        framing_err <= fe_next;
                        if (last_stop) state <= is_break ? S_BREAK_WAIT : S_IDLE;
                        else           stop_cnt <= 1'b1;
                    end
                end
                S_BREAK_WAIT: begin
                    cyc <= '0;
                    if (rx_s) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign full  = (count == (PW+1)'(FIFO_DEPTH));
    assign pop   = valid_out && ready_in;
    assign wr_en = push && (!full || pop);

    always_ff @(posedge clk_in) begin
        if (wr_en) mem[wr_ptr] <= {fe_next, parity_err, shift};
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            overrun_out <= 1'b0;
        end else begin
            overrun_out <= push && full && !pop;
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            if (wr_en && !pop)      count <= count + 1'b1;
            else if (pop && !wr_en) count <= count - 1'b1;
        end
    end

    assign head            = mem[rd_ptr];
    assign valid_out       = (count != '0);
    assign fifo_count_out  = count;
    assign data_out        = valid_out ? head[DATA_BITS-1:0] : '0;
    assign parity_err_out  = (PARITY != 0) && valid_out && head[DATA_BITS];
    assign framing_err_out = valid_out && head[DATA_BITS+1];

endmodule
